// File: rtl/simd_data_mem_responder_pkg.sv
// Shared types and MMIO offsets for the SIMD data-memory responder.
// Pure declarations; no timing or flow-control behaviour of its own.
package dmem_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [7:0] LED_OFF  = 8'h00;
  localparam logic [7:0] SW_OFF   = 8'h04;
  localparam logic [7:0] SCNT_OFF = 8'h08;
  localparam logic [7:0] VCNT_OFF = 8'h0C;

  typedef logic [127:0] line_t;

  function automatic logic [31:0] laneOf(input line_t line, input logic [1:0] lane);
    return line[{lane, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/simd_data_mem_responder_mmio.sv
// MMIO block: LED register, 2-flop switch synchroniser, optional access counters.
// Read data is combinational (registered by the top); writes land at the clock edge, no stalls.
module dmem_mmio
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wrEn,
  input  logic [7:0]  offset,
  input  logic [7:0]  wdata,
`ifdef DMEM_ACCESS_COUNTERS_EN
  input  logic        sAccess,
  input  logic        vAccess,
`endif
  input  logic [2:0]  switches,
  output logic [7:0]  leds,
  output logic [31:0] rdata
);

  logic [2:0] swMeta;
  logic [2:0] swSync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds   <= '0;
      swMeta <= '0;
      swSync <= '0;
    end else begin
      swMeta <= switches;
      swSync <= swMeta;
      if (wrEn && offset == LED_OFF) leds <= wdata;
    end
  end

`ifdef DMEM_ACCESS_COUNTERS_EN
  logic [31:0] sCount, vCount, sCountNext, vCountNext;

  // Clear beats a same-cycle increment; reads return the post-update value so an access counts itself.
  always_comb begin
    sCountNext = sCount + {31'b0, sAccess};
    vCountNext = vCount + {31'b0, vAccess};
    if (wrEn && offset == SCNT_OFF) sCountNext = '0;
    if (wrEn && offset == VCNT_OFF) vCountNext = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sCount <= '0;
      vCount <= '0;
    end else begin
      sCount <= sCountNext;
      vCount <= vCountNext;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (offset)
      LED_OFF:  rdata = {24'b0, leds};
      SW_OFF:   rdata = {29'b0, swSync};
`ifdef DMEM_ACCESS_COUNTERS_EN
      SCNT_OFF: rdata = sCountNext;
      VCNT_OFF: rdata = vCountNext;
`endif
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/simd_data_mem_responder.sv
// Scalar + vector data-memory responder with zero-fill sweep after reset and an MMIO window.
// One-cycle registered reads, read-first, no backpressure; optional counters via DMEM_ACCESS_COUNTERS_EN.
module simd_data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          LINES     = 256,
  parameter int          LINE_AW   = $clog2(LINES),
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ready,
  input  logic [31:0]  s_addr,
  input  logic         s_we,
  input  logic [31:0]  s_wdata,
  output logic [31:0]  s_rdata,
  input  logic [31:0]  v_addr,
  input  logic         v_we,
  input  logic [127:0] v_wdata,
  output logic [127:0] v_rdata,
  output logic [7:0]   leds,
  input  logic [2:0]   switches,
  output logic         oor_err
);

  localparam logic [LINE_AW-1:0] LAST_LINE = LINE_AW'(LINES - 1);

  state_t             state, stateNext;
  logic               sweepWr;
  logic [LINE_AW-1:0] sweepCnt;
  line_t              mem [LINES];

  logic [LINE_AW-1:0] sLine, vLine;
  logic               sInRange, vInRange, sMmio;
  logic               sWr, vWr, mmioWr;
  logic [7:0]         mmioOff;
  logic [31:0]        mmioRdata;
  line_t              sMerged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == INIT && sweepCnt == LAST_LINE) stateNext = RUN;
  end

  always_comb begin
    ready   = (state == RUN);
    sweepWr = (state == INIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       sweepCnt <= '0;
    else if (sweepWr) sweepCnt <= sweepCnt + LINE_AW'(1);
  end

  assign sLine    = s_addr[LINE_AW+3:4];
  assign vLine    = v_addr[LINE_AW+3:4];
  assign sInRange = (s_addr >> (LINE_AW + 4)) == 32'd0;
  assign vInRange = (v_addr >> (LINE_AW + 4)) == 32'd0;
  assign sMmio    = (s_addr[31:8] == MMIO_BASE[31:8]);
  assign mmioOff  = {s_addr[7:2], 2'b00};

  assign sWr    = ready && s_we && sInRange;
  assign vWr    = ready && v_we && vInRange;
  assign mmioWr = ready && s_we && sMmio;

  // On a same-line collision the scalar lane is merged over the vector data, not the stored line.
  always_comb begin
    sMerged = (vWr && vLine == sLine) ? v_wdata : mem[sLine];
    sMerged[{s_addr[3:2], 5'b0} +: 32] = s_wdata;
  end

  always_ff @(posedge clk) begin
    if (sweepWr) begin
      mem[sweepCnt] <= '0;
    end else begin
      if (vWr) mem[vLine] <= v_wdata;
      if (sWr) mem[sLine] <= sMerged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_rdata <= '0;
      v_rdata <= '0;
      oor_err <= 1'b0;
    end else if (!ready) begin
      s_rdata <= '0;
      v_rdata <= '0;
    end else begin
      s_rdata <= sInRange ? laneOf(mem[sLine], s_addr[3:2]) : (sMmio ? mmioRdata : '0);
      v_rdata <= vInRange ? mem[vLine] : '0;
      if (!(sInRange || sMmio) || !vInRange) oor_err <= 1'b1;
    end
  end

  dmem_mmio uMmio (
    .clk      (clk),
    .reset    (reset),
    .wrEn     (mmioWr),
    .offset   (mmioOff),
    .wdata    (s_wdata[7:0]),
`ifdef DMEM_ACCESS_COUNTERS_EN
    .sAccess  (ready && (sInRange || sMmio)),
    .vAccess  (ready && vInRange),
`endif
    .switches (switches),
    .leds     (leds),
    .rdata    (mmioRdata)
  );

endmodule

// File: doc/simd_data_mem_responder.md
Name: simd_data_mem_responder

Overview:
- Memory-side responder for the core's two data ports: 32-bit scalar port (E-stage address/write, M-stage read data) and 128-bit vector port.
- Holds the data memory as 128-bit lines, services both ports every cycle, and decodes a small MMIO window for LEDs and switches.
- After reset, a sweep state machine zero-fills memory before asserting ready.

Parameters:
- LINES, 256, number of 128-bit memory lines (power of two)
- LINE_AW, $clog2(LINES), line index width (derived)
- MMIO_BASE, 32'hFFFF_FF00, base of MMIO window (256-byte aligned)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ready  out  1  memory initialised, accesses honoured
- s_addr  in  32  scalar byte address (word-aligned, bits[1:0] ignored)
- s_we  in  1  scalar write enable
- s_wdata  in  32  scalar write data
- s_rdata  out  32  scalar read data, registered
- v_addr  in  32  vector byte address (line-aligned, bits[3:0] ignored)
- v_we  in  1  vector write enable
- v_wdata  in  128  vector write data
- v_rdata  out  128  vector read data, registered
- leds  out  8  LED register
- switches  in  3  asynchronous switch inputs
- oor_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset (reset=0, async): FSM→INIT, sweep counter=0, ready=0, s_rdata=0, v_rdata=0, leds=0, oor_err=0, switch synchroniser flops=0. Memory array is not reset directly; the INIT sweep clears it.
- FSM INIT: each cycle write zero to line[counter], counter++. After line LINES-1 is written → RUN. ready=1 from the first RUN cycle, so INIT lasts exactly LINES cycles.
- INIT access handling: port writes dropped, rdata outputs forced to 0, oor_err not updated.
- FSM RUN: stays until reset.
- Memory decode: in range iff addr[31:LINE_AW+4]==0. Line index = addr[LINE_AW+3:4]. Scalar lane = addr[3:2], where lane 0 is bits[31:0].
- Scalar MMIO (addr[31:8]==MMIO_BASE[31:8]):
  - offset 0x00: LEDs. Write loads wdata[7:0]. Read returns {24'b0, leds}.
  - offset 0x04: switches. Read-only. Returns {29'b0, sync_sw}, where sync_sw is a 2-flop synchroniser output.
  - other offsets: read 0, write ignored.
- Vector MMIO: the vector port has no MMIO. MMIO addresses on v_addr count as out of range.
- Out of range (neither decode) with a read or write: write ignored, rdata next cycle=0, oor_err set. Only reset clears oor_err.
- Read latency: one cycle. Address presented at edge N → data valid after edge N+1. Reads occur every RUN cycle regardless of we.
- Read-during-write, same port and same line: old data returned (read-first).
- Cross-port, same cycle, same line:
  - Vector write is applied first, then the scalar write lane overrides it. Final line = v_wdata with lane addr[3:2] replaced by s_wdata.
  - Reads on either port return pre-write contents.
- Both ports writing different lines: both commit in the same cycle.

Optional Feature:
- Macro DMEM_ACCESS_COUNTERS_EN.
- Defined:
  - Two 32-bit free-running counters, s_count (RUN-cycle scalar memory/MMIO accesses with in-range or MMIO decode) and v_count (in-range vector accesses). A RUN-cycle access is either we=1 or a decode hit.
  - Both are zeroed by reset and wrap at 2^32.
  - Readable at MMIO offsets 0x08 and 0x0C. A write to either offset clears that counter; clear wins over a same-cycle increment.
- Undefined: offsets 0x08/0x0C read 0 and no counter logic is built.

Decomposition:
- Package dmem_pkg:
  - state enum {INIT, RUN}
  - MMIO offset constants LED_OFF=8'h00, SW_OFF=8'h04, SCNT_OFF=8'h08, VCNT_OFF=8'h0C
  - typedef line_t = logic [127:0]
- One sub-module, dmem_mmio: LED register, switch synchroniser, optional counters, MMIO read mux. Top holds the FSM, array, decode and port merge.

Test Plan:
- Reset release with LINES=256: ready=0 for 256 cycles then 1; a read of line 17 returns 0 on both ports.
- RUN: vector write 0x0123..CDEF to addr 0x40, then scalar read 0x48 → s_rdata equals lane 2 one cycle after the address.
- Same cycle: v_we to 0x40 with all 0xAA, plus s_we 0x44 = 0x12345678 → subsequent v_rdata = {AA..,AA..,12345678,AA..}. Both same-cycle reads return old data.
- Scalar write 0xFFFF_FF00 = 0x1A5 → leds=0xA5. With switches=3'b101, read 0xFFFF_FF04 → 0x5 once 2 sync cycles have elapsed.
- Scalar write to 0x0001_0000 (LINE_AW=8) → no memory change, oor_err=1, read there returns 0. Vector access at 0xFFFF_FF00 also sets oor_err.
- Assert reset mid-RUN with leds=0xFF and a write pending → leds=0 and ready=0 immediately; INIT re-sweeps and prior data reads 0. With DMEM_ACCESS_COUNTERS_EN, 3 scalar reads then read 0x08 → 4 (the 0x08 read itself counts).
